spi_master: RTL and testbench

// - SPI mode-0 master (CPOL=0), MSB first, for driving the team's spi_slave from an FPGA/CPLD host side.
// - Fully synchronous to i_clk. Generates o_sck, o_ssel_n and o_mosi, and samples i_miso.
// - One request frames one transfer of FRAME_BITS bits. The received word and a done pulse are returned to the host logic.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_sck_gen.sv | 53 +++++
 rtl/spi_master.sv | 142 ++++++++++++++
 tb/tb_spi_master.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, bus idle levels
// and the default frame width.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_TRAIL = 2'd3
    } spi_state_e;

    localparam logic SCK_IDLE       = 1'b0;
    localparam logic MOSI_IDLE      = 1'b1;
    localparam int   DEF_FRAME_BITS = 16;

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock generator: CLK_DIV i_clk cycles per half-period, SCK parked low
// while disabled, with single-cycle strobes marking each upcoming edge.
module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_sck,
    output logic o_rise_stb,
    output logic o_fall_stb
);

    localparam int                 DIV_W  = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0]   DIV_TC = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             sck_q, sck_d;
    logic             tc;

    // Strobes flag the cycle whose closing edge toggles SCK.
    assign tc         = i_en && (div_q == DIV_TC);
    assign o_rise_stb = tc && !sck_q;
    assign o_fall_stb = tc && sck_q;
    assign o_sck      = sck_q;

    always_comb begin
        div_d = div_q;
        sck_d = sck_q;
        if (!i_en) begin
            div_d = '0;
            sck_d = SCK_IDLE;
        end else if (tc) begin
            div_d = '0;
            sck_d = ~sck_q;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_q <= '0;
            sck_q <= SCK_IDLE;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first: frames one FRAME_BITS transfer per accepted
// request and returns the received word with a one-cycle done pulse.
module spi_master
    import spi_pkg::*;
#(
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int CLK_DIV    = 4,
    parameter int CS_LEAD    = 4,
    parameter int CS_TRAIL   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [FRAME_BITS-1:0] i_tx_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [FRAME_BITS-1:0] o_rx_data,
    output logic                  o_sck,
    output logic                  o_ssel_n,
    output logic                  o_mosi,
    input  logic                  i_miso
);

    localparam int               BIT_W  = $clog2(FRAME_BITS + 1);
    localparam int               CS_MAX = (CS_LEAD > CS_TRAIL) ? CS_LEAD : CS_TRAIL;
    localparam int               CS_W   = $clog2(CS_MAX + 1);
    localparam logic [BIT_W-1:0] BIT_TC = BIT_W'(FRAME_BITS);

    spi_state_e            state_q, state_d;
    logic [FRAME_BITS-1:0] tx_sr_q, tx_sr_d;
    logic [FRAME_BITS-1:0] rx_sr_q, rx_sr_d;
    logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [CS_W-1:0]       cs_cnt_q, cs_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ssel_n_q, ssel_n_d;
    logic                  mosi_q, mosi_d;
    logic                  rise_stb, fall_stb;

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (state_q == ST_SHIFT),
        .o_sck      (o_sck),
        .o_rise_stb (rise_stb),
        .o_fall_stb (fall_stb)
    );

    always_comb begin
        state_d   = state_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        cs_cnt_d  = cs_cnt_q;
        ssel_n_d  = ssel_n_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The done cycle still counts as the tail of the previous frame.
                if (i_start && !done_q) begin
                    state_d   = ST_LEAD;
                    tx_sr_d   = i_tx_data;
                    rx_sr_d   = '0;
                    bit_cnt_d = '0;
                    cs_cnt_d  = CS_W'(CS_LEAD - 1);
                    ssel_n_d  = 1'b0;
                    mosi_d    = i_tx_data[FRAME_BITS-1];
                end
            end
            ST_LEAD: begin
                mosi_d = tx_sr_q[FRAME_BITS-1];
                if (cs_cnt_q == '0) state_d = ST_SHIFT;
                else                cs_cnt_d = cs_cnt_q - CS_W'(1);
            end
            ST_SHIFT: begin
                // Rises are counted so the final fall is recognised at BIT_TC.
                if (rise_stb) bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (fall_stb) begin
                    rx_sr_d = {rx_sr_q[FRAME_BITS-2:0], i_miso};
                    tx_sr_d = {tx_sr_q[FRAME_BITS-2:0], 1'b1};
                    mosi_d  = tx_sr_q[FRAME_BITS-2];
                    if (bit_cnt_q == BIT_TC) begin
                        bit_cnt_d = '0;
                        state_d   = ST_TRAIL;
                        cs_cnt_d  = CS_W'(CS_TRAIL - 1);
                        mosi_d    = MOSI_IDLE;
                    end
                end
            end
            ST_TRAIL: begin
                if (cs_cnt_q == '0) begin
                    state_d   = ST_IDLE;
                    ssel_n_d  = 1'b1;
                    rx_data_d = rx_sr_q;
                    done_d    = 1'b1;
                end else begin
                    cs_cnt_d = cs_cnt_q - CS_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            cs_cnt_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ssel_n_q  <= 1'b1;
            mosi_q    <= MOSI_IDLE;
        end else begin
            state_q   <= state_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            cs_cnt_q  <= cs_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ssel_n_q  <= ssel_n_d;
            mosi_q    <= mosi_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_rx_data = rx_data_q;
    assign o_ssel_n  = ssel_n_q;
    assign o_mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a 16-bit default instance and a 2-bit,
// CLK_DIV=1 instance, each with a mode-0 slave model on the SPI pins.
module tb_spi_master;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, busy, done, sck, ssel_n, mosi, miso;
    logic [15:0] tx, rx;
    logic        start2, busy2, done2, sck2, ssel_n2, mosi2, miso2;
    logic [1:0]  tx2, rx2;

    logic [15:0] miso_word, mosi_cap;
    logic [1:0]  miso_word2, mosi_cap2;
    int          idx1, idx2;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;

    spi_master dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_tx_data(tx),
        .o_busy(busy), .o_done(done), .o_rx_data(rx),
        .o_sck(sck), .o_ssel_n(ssel_n), .o_mosi(mosi), .i_miso(miso)
    );

    spi_master #(.FRAME_BITS(2), .CLK_DIV(1)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_tx_data(tx2),
        .o_busy(busy2), .o_done(done2), .o_rx_data(rx2),
        .o_sck(sck2), .o_ssel_n(ssel_n2), .o_mosi(mosi2), .i_miso(miso2)
    );

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    // Slave models: update miso and capture mosi on each sck rise.
    initial begin
        miso = 1'b0; idx1 = 0; mosi_cap = '0;
        forever begin
            @(posedge sck or negedge ssel_n);
            if (sck === 1'b1) begin
                if (idx1 < 16) miso = miso_word[15-idx1];
                mosi_cap = {mosi_cap[14:0], mosi};
                idx1++;
            end else begin
                idx1 = 0; mosi_cap = '0;
            end
        end
    end

    initial begin
        miso2 = 1'b0; idx2 = 0; mosi_cap2 = '0;
        forever begin
            @(posedge sck2 or negedge ssel_n2);
            if (sck2 === 1'b1) begin
                if (idx2 < 2) miso2 = miso_word2[1-idx2];
                mosi_cap2 = {mosi_cap2[0], mosi2};
                idx2++;
            end else begin
                idx2 = 0; mosi_cap2 = '0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (done !== 1'b1 && k < 400);
    endtask

    int          k, base;
    logic [4:0]  sck_trace;

    initial begin
        rst = 1'b1; start = 1'b0; tx = '0; start2 = 1'b0; tx2 = '0;
        miso_word = '0; miso_word2 = '0;
        repeat (3) tick();
        check("rst_sck", sck, 0);
        check("rst_ssel_n", ssel_n, 1);
        check("rst_mosi", mosi, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rx", rx, 0);
        check("rst_ssel_n2", ssel_n2, 1);
        rst = 1'b0;
        tick();

        // Frame A5C3 / 3C5A with latency and single done pulse.
        tx = 16'hA5C3; miso_word = 16'h3C5A; start = 1'b1;
        tick();
        start = 1'b0; tx = 16'h0000;
        check("lead_busy", busy, 1);
        check("lead_ssel_n", ssel_n, 0);
        check("lead_mosi_msb", mosi, 1);
        base = done_cnt;
        wait_done(k);
        check("f1_latency", k + 1, 135);
        check("f1_rx", rx, 16'h3C5A);
        check("f1_mosi_stream", mosi_cap, 16'hA5C3);
        check("f1_ssel_n_done", ssel_n, 1);
        tick();
        check("f1_done_width", done, 0);
        check("f1_done_count", done_cnt - base, 1);

        // Back-to-back frames, second start raised in the done cycle.
        tx = 16'h0001; miso_word = 16'h0F0F; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(k);
        check("f2a_latency", k + 1, 135);
        check("f2a_rx", rx, 16'h0F0F);
        check("f2a_mosi_stream", mosi_cap, 16'h0001);
        tx = 16'h8000; miso_word = 16'hF00F; start = 1'b1;
        tick();
        check("f2_ignored_busy", busy, 0);
        check("f2_gap_ssel_n", ssel_n, 1);
        tick();
        start = 1'b0;
        check("f2b_accept_busy", busy, 1);
        check("f2b_accept_ssel_n", ssel_n, 0);
        wait_done(k);
        check("f2b_latency", k + 2, 136);
        check("f2b_rx", rx, 16'hF00F);
        check("f2b_mosi_stream", mosi_cap, 16'h8000);
        tick();

        // Start pulsed mid-SHIFT must not disturb or add a frame.
        tx = 16'h1357; miso_word = 16'h2468; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (50) tick();
        tx = 16'hFFFF; start = 1'b1;
        tick();
        start = 1'b0; tx = 16'h0000;
        base = done_cnt;
        wait_done(k);
        check("f3_latency", k + 52, 135);
        check("f3_rx", rx, 16'h2468);
        check("f3_mosi_stream", mosi_cap, 16'h1357);
        repeat (200) tick();
        check("f3_done_count", done_cnt - base, 1);
        check("f3_idle_busy", busy, 0);

        // Reset during bit 7 while sck is high.
        tx = 16'h0000; miso_word = 16'hFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (57) tick();
        check("f4_pre_sck", sck, 1);
        check("f4_pre_mosi", mosi, 0);
        base = done_cnt;
        rst = 1'b1;
        #1;
        check("f4_rst_sck", sck, 0);
        check("f4_rst_ssel_n", ssel_n, 1);
        check("f4_rst_mosi", mosi, 1);
        check("f4_rst_busy", busy, 0);
        check("f4_rst_rx", rx, 0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("f4_no_done", done_cnt - base, 0);
        check("f4_rx_kept_clear", rx, 0);
        tx = 16'hC001; miso_word = 16'h8003; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(k);
        check("f5_latency", k + 1, 135);
        check("f5_rx", rx, 16'h8003);
        check("f5_mosi_stream", mosi_cap, 16'hC001);
        tick();

        // Minimal instance: CLK_DIV=1, FRAME_BITS=2.
        tx2 = 2'b10; miso_word2 = 2'b01; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("m_lead_ssel_n", ssel_n2, 0);
        check("m_lead_mosi", mosi2, 1);
        k = 1; sck_trace = '0;
        while (done2 !== 1'b1 && k < 40) begin
            tick();
            k++;
            if (k >= 5 && k <= 9) sck_trace = {sck_trace[3:0], sck2};
        end
        check("m_latency", k, 11);
        check("m_sck_trace", sck_trace, 5'b01010);
        check("m_rx", rx2, 2'b01);
        check("m_mosi_stream", mosi_cap2, 2'b10);
        tick();
        check("m_done_width", done2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
